// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and default frame width.
// Ports: none (package).
// Imported by the interface and the top level so all agree on widths and states.
package spi_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_sys_if.sv
// Host-side bundle of the SPI slave: tx holding-register handshake, rx frame output, status.
// Ports: slave modport is the block's view (drives rx/status, consumes tx_data/tx_valid);
//        master modport is the host's view.
interface spi_slave_sys_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_err;
    logic              busy;
    logic [CNT_W-1:0]  bit_count;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy, bit_count
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy, bit_count
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin followed by an edge-detect flop.
// Ports: clk/reset, din (async pin) -> level (synchronized), rise/fall (one-cycle pulses).
// IDLE_VAL is the pin's idle level, loaded on reset so no spurious edge follows reset release.
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_sys.sv
// SPI mode-0 slave oversampled by clk: one DATA_W-bit frame per chip-select window, MSB first.
// Ports: clk, reset (async active-low), SPI pins spi_sclk/spi_cs_l/spi_mosi/spi_miso,
//        host bundle (tx holding register handshake, rx_data/rx_valid, error pulses, busy, bit_count).
module spi_slave_sys
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_l,
    input  logic             spi_mosi,
    output logic             spi_miso,
    spi_slave_sys_if.slave   host
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_t state_q, state_d;

    logic sclk_level_unused;   // only sclk edges drive the protocol
    logic sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-2:0] rx_shift_q;    // final bit is appended straight into rx_data
    logic [DATA_W-1:0] rx_data_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              rx_valid_q, underrun_q, frame_err_q;

    logic start, sample, complete, shift_out, abort;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_cs_l),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI needs only the level; same depth keeps it aligned with the sclk edge pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        // cs_level is high only on the release cycle inside a frame; release wins over sclk.
        sample    = (state_q == ST_SHIFT) && sclk_rise && !cs_level;
        complete  = sample && (bit_cnt_q == LAST_BIT);
        shift_out = (state_q == ST_SHIFT) && sclk_fall && !cs_level &&
                    (bit_cnt_q != '0) && (bit_cnt_q < CNT_W'(DATA_W));
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    start   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (complete) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cs_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // The frame takes the holding content from before this edge; a write landing on
            // the start cycle is kept for the following frame.
            if (host.tx_valid && !hold_full_q) begin
                hold_q      <= host.tx_data;
                hold_full_q <= 1'b1;
            end else if (start) begin
                hold_full_q <= 1'b0;
            end

            if (start) begin
                tx_shift_q <= hold_full_q ? hold_q : '0;
                underrun_q <= !hold_full_q;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end

            if (sample) begin
                rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            end

            if (complete) begin
                rx_data_q  <= {rx_shift_q, mosi_s};
                rx_valid_q <= 1'b1;
            end

            if (shift_out) tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};

            if (abort) frame_err_q <= 1'b1;
        end
    end

    assign spi_miso         = (state_q != ST_IDLE) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign host.tx_ready    = !hold_full_q;
    assign host.rx_data     = rx_data_q;
    assign host.rx_valid    = rx_valid_q;
    assign host.tx_underrun = underrun_q;
    assign host.frame_err   = frame_err_q;
    assign host.busy        = (state_q != ST_IDLE);
    assign host.bit_count   = bit_cnt_q;

endmodule

// File: doc/spi_slave_sys.md
SPI_SLAVE_SYS -- requirements
Module: spi_slave_sys

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which sets the frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, which sets the synchronizer depth on spi_sclk, spi_cs_l and spi_mosi.
REQ-003 SHALL have these ports:
- clk  input  1  system clock; the only clock in the block.
- reset  input  1  asynchronous, active-low reset.
- spi_sclk  input  1  SPI clock from the master; CPOL=0.
- spi_cs_l  input  1  active-low chip select from the master.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data, MSB first.
- tx_data  input  DATA_W  next frame to return to the master.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty.
- rx_data  output  DATA_W  last complete frame received.
- rx_valid  output  1  one-cycle pulse: rx_data has been updated.
- tx_underrun  output  1  one-cycle pulse: frame started with the holding register empty.
- frame_err  output  1  one-cycle pulse: chip select released before DATA_W bits.
- busy  output  1  state is not IDLE.
- bit_count  output  $clog2(DATA_W)+1  number of bits received in the current frame.

Function
REQ-004 SHALL pass spi_sclk, spi_cs_l and spi_mosi through SYNC_STAGES flops, then one edge-detect flop; all protocol logic SHALL use the synchronized signals only.
REQ-005 SHALL support mode 0 only: MOSI sampled on each synchronized sclk rising edge; MISO shifted on each synchronized sclk falling edge.
REQ-006 SHALL require sclk high and low phases of at least SYNC_STAGES+1 clk cycles each; behaviour with faster sclk is undefined.
REQ-007 SHALL implement the FSM IDLE, SHIFT, DONE:
- IDLE->SHIFT on a synchronized cs_l falling edge.
- SHIFT->DONE when bit_count reaches DATA_W.
- SHIFT->IDLE on a cs_l rising edge.
- DONE->IDLE on a cs_l rising edge.
REQ-008 SHALL apply the following tx holding-register rules:
- tx_ready=1 when the holding register is empty.
- tx_valid&&tx_ready loads tx_data into the holding register and drops tx_ready on the next cycle.
- tx_data is ignored while tx_ready=0.
REQ-009 SHALL, on entering SHIFT, do the following:
- Load the tx shift register from the holding register and empty the holding register.
- If the holding register was empty, load all-zeros and pulse tx_underrun.
- Clear bit_count and the rx shift register.
REQ-010 SHALL, when tx_valid&&tx_ready coincides with the cs_l falling-edge cycle, start the current frame from the holding content before the edge (underrun if empty) and keep the new data in the holding register for the next frame.
REQ-011 SHALL drive spi_miso from the tx shift register MSB while in SHIFT or DONE, and 0 in IDLE.
REQ-012 SHALL, on each rising edge in SHIFT, shift the synchronized MOSI into the rx shift register LSB and increment bit_count.
REQ-013 SHALL, on each falling edge in SHIFT with 1<=bit_count<DATA_W, shift the tx shift register left by one with zero fill.
REQ-014 SHALL, on the cycle bit_count reaches DATA_W, copy the rx shift register (including the final bit) to rx_data and pulse rx_valid for exactly one clk.
REQ-015 SHALL assert rx_valid no later than SYNC_STAGES+3 clk cycles after the 16th pin-level sclk rising edge.
REQ-016 SHALL hold rx_data until the next completed frame; an aborted frame SHALL NOT modify rx_data.
REQ-017 SHALL, on a cs_l rising edge in SHIFT with bit_count<DATA_W, pulse frame_err, suppress rx_valid and return to IDLE.
REQ-018 SHALL ignore sclk edges while in IDLE or DONE.
REQ-019 SHALL drive busy=1 exactly while the state is SHIFT or DONE.

Reset
REQ-020 SHALL, while reset=0, asynchronously clear all state:
- state=IDLE, synchronizers=idle (sclk 0, cs_l 1, mosi 0).
- Holding register empty, so tx_ready=1.
- rx_data=0, shift registers=0, bit_count=0.
- rx_valid, tx_underrun, frame_err, busy and spi_miso all 0.
REQ-021 SHALL treat a reset mid-frame as an abort with no rx_valid; after release the block SHALL wait in IDLE for a new cs_l falling edge.

Structure
REQ-022 SHALL define the FSM state enum and the DATA_W default in a shared package spi_pkg.
REQ-023 SHALL implement synchronizer plus edge detect as sub-module spi_sync_edge (outputs: level, rise, fall), instanced for sclk and cs_l; mosi SHALL use the level output only.

Verification
REQ-024 Holding register loaded with 16'hA5C3, master sends 16'h3C5A -> MISO bitstream A5C3 MSB first; rx_data=16'h3C5A; one rx_valid pulse; tx_ready=1 after cs_l falls.
REQ-025 No tx load before cs_l falls, master sends 16'hFFFF -> tx_underrun pulse at frame start; MISO all 0; rx_data=16'hFFFF.
REQ-026 cs_l released after 9 sclk rising edges -> frame_err pulse, no rx_valid, rx_data unchanged, state IDLE.
REQ-027 tx_valid with 16'h1234 in the same cycle as the synchronized cs_l fall, holding empty -> current frame underruns; the next frame returns 16'h1234.
REQ-028 reset driven low after 8 bits -> all outputs at reset values; a following full frame with 16'h0F0F completes correctly.
REQ-029 Three back-to-back frames with cs_l high for 4 clk between them, sclk half-period 3 clk -> three rx_valid pulses with correct data.
